// File: rtl/board_io_ctrl.sv
// Board I/O controller: button debounce, trace channel select/freeze onto LEDs, SoC reset stretch.
// Optional build macro BOARD_IO_BTN_RESET_EN lets the SOCRST button restart the reset stretch.
module board_io_ctrl #(
  parameter int unsigned CORES          = 4,
  parameter int unsigned TRACE_W        = 8,
  parameter int unsigned RST_W          = 23,
  parameter int unsigned DB_W           = 16,
  parameter int unsigned LED_ACTIVE_LOW = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [2:0]                    btn,
  input  logic [CORES*TRACE_W-1:0]      trace_in,
  output logic                          soc_rst_n,
  output logic [TRACE_W-1:0]            led,
  output logic [CORES-1:0]              chan_led,
  output logic [((CORES > 1) ? $clog2(CORES) : 1)-1:0] sel
);

  localparam int unsigned SEL_W = (CORES > 1) ? $clog2(CORES) : 1;
  localparam int unsigned BTN_N = 3;
  localparam logic [TRACE_W-1:0] LED_POL  = (LED_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [CORES-1:0]   CHAN_POL = (LED_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [CORES-1:0]   CHAN_RST = CHAN_POL ^ CORES'(1);
`ifdef BOARD_IO_BTN_RESET_EN
  localparam int unsigned PRESS_N = 3;
`else
  localparam int unsigned PRESS_N = 2;
`endif

  logic [BTN_N-1:0]   sync1_q, sync1_d, sync2_q, sync2_d;
  logic [BTN_N-1:0]   stable_q, stable_d;
  logic [DB_W-1:0]    cnt_q [BTN_N];
  logic [DB_W-1:0]    cnt_d [BTN_N];
  logic [PRESS_N-1:0] press_c;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               frozen_q, frozen_d;
  logic [TRACE_W-1:0] led_q, led_d;
  logic [CORES-1:0]   chan_led_q, chan_led_d;
  logic [RST_W-1:0]   rcnt_q, rcnt_d;
  logic               soc_rst_n_q, soc_rst_n_d;
  logic [TRACE_W-1:0] trace_sel_c;
  logic [CORES-1:0]   onehot_c;

  always_comb begin
    sync1_d     = btn;
    sync2_d     = sync1_q;
    stable_d    = stable_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    frozen_d    = frozen_q;
    led_d       = led_q;
    rcnt_d      = rcnt_q;
    trace_sel_c = '0;
    onehot_c    = '0;

    // Debounce: count while input disagrees with stable state, commit when counter saturates
    for (int i = 0; i < int'(BTN_N); i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (&cnt_q[i]) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DB_W'(1);
      end
    end
    press_c = stable_d[PRESS_N-1:0] & ~stable_q[PRESS_N-1:0];

    // NEXT advance uses the frozen flag from before this edge; FREEZE toggle always applies
    if (press_c[0] && !frozen_q) begin
      sel_d = (sel_q == SEL_W'(CORES - 1)) ? '0 : sel_q + SEL_W'(1);
    end
    if (press_c[1]) begin
      frozen_d = ~frozen_q;
    end

    for (int k = 0; k < int'(CORES); k++) begin
      if (SEL_W'(k) == sel_q) begin
        trace_sel_c = trace_in[k*TRACE_W +: TRACE_W];
      end
      onehot_c[k] = (SEL_W'(k) == sel_d);
    end
    if (!frozen_q) begin
      led_d = trace_sel_c ^ LED_POL;
    end
    chan_led_d = onehot_c ^ CHAN_POL;

    if (!(&rcnt_q)) begin
      rcnt_d = rcnt_q + RST_W'(1);
    end
    soc_rst_n_d = &rcnt_q;
`ifdef BOARD_IO_BTN_RESET_EN
    // Restart the stretch; force low on the press edge so the low window is a full 2^RST_W cycles
    if (press_c[2]) begin
      rcnt_d      = '0;
      soc_rst_n_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      for (int i = 0; i < int'(BTN_N); i++) begin
        cnt_q[i] <= '0;
      end
      sel_q       <= '0;
      frozen_q    <= 1'b0;
      led_q       <= LED_POL;
      chan_led_q  <= CHAN_RST;
      rcnt_q      <= '0;
      soc_rst_n_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      stable_q    <= stable_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      frozen_q    <= frozen_d;
      led_q       <= led_d;
      chan_led_q  <= chan_led_d;
      rcnt_q      <= rcnt_d;
      soc_rst_n_q <= soc_rst_n_d;
    end
  end

  assign soc_rst_n = soc_rst_n_q;
  assign led       = led_q;
  assign chan_led  = chan_led_q;
  assign sel       = sel_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed self-checking bench for board_io_ctrl (CORES=4, TRACE_W=8, RST_W=4, DB_W=3, active-low LEDs).
module tb_board_io_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  btn;
  logic [31:0] trace_in;
  logic        soc_rst_n;
  logic [7:0]  led;
  logic [3:0]  chan_led;
  logic [1:0]  sel;

  int total = 0;
  int bad   = 0;

  board_io_ctrl #(
    .CORES(4), .TRACE_W(8), .RST_W(4), .DB_W(3), .LED_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .trace_in(trace_in),
    .soc_rst_n(soc_rst_n), .led(led), .chan_led(chan_led), .sel(sel)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold buttons long enough to debounce, then release and let the release settle
  task automatic press(input logic [2:0] b);
    btn = b;
    tick(14);
    btn = 3'b000;
    tick(14);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    btn = 3'b000;
    trace_in = {8'h81, 8'h0F, 8'h3C, 8'hA5};
    tick(3);
    total++; if (sel !== 2'd0) begin bad++; $display("FAIL rst_sel got=%0d exp=0", sel); end
    total++; if (chan_led !== 4'b1110) begin bad++; $display("FAIL rst_chan_led got=%b exp=1110", chan_led); end
    total++; if (led !== 8'hFF) begin bad++; $display("FAIL rst_led got=%h exp=ff", led); end
    total++; if (soc_rst_n !== 1'b0) begin bad++; $display("FAIL rst_soc got=%b exp=0", soc_rst_n); end
    rst = 1'b0;
    for (int e = 1; e <= 17; e++) begin
      tick(1);
      total++;
      if (soc_rst_n !== (e >= 16)) begin
        bad++; $display("FAIL stretch_edge%0d got=%b exp=%b", e, soc_rst_n, (e >= 16));
      end
    end
  endtask

  task automatic test_trace;
    total++; if (led !== 8'h5A) begin bad++; $display("FAIL trace_ch0 got=%h exp=5a", led); end
    trace_in[7:0] = 8'h11;
    total++; if (led !== 8'h5A) begin bad++; $display("FAIL trace_latency_old got=%h exp=5a", led); end
    tick(1);
    total++; if (led !== 8'hEE) begin bad++; $display("FAIL trace_latency_new got=%h exp=ee", led); end
    trace_in[7:0] = 8'hA5;
    tick(1);
  endtask

  task automatic test_debounce;
    int changes;
    logic [1:0] prev;
    btn = 3'b001;
    tick(5);
    btn = 3'b000;
    tick(15);
    total++; if (sel !== 2'd0) begin bad++; $display("FAIL glitch_sel got=%0d exp=0", sel); end
    changes = 0;
    prev = sel;
    btn = 3'b001;
    for (int i = 0; i < 27; i++) begin
      if (i == 12) btn = 3'b000;
      tick(1);
      if (sel !== prev) changes++;
      prev = sel;
    end
    total++; if (sel !== 2'd1) begin bad++; $display("FAIL held_sel got=%0d exp=1", sel); end
    total++; if (changes !== 1) begin bad++; $display("FAIL held_changes got=%0d exp=1", changes); end
    total++; if (chan_led !== 4'b1101) begin bad++; $display("FAIL chan_sel1 got=%b exp=1101", chan_led); end
    total++; if (led !== 8'hC3) begin bad++; $display("FAIL led_sel1 got=%h exp=c3", led); end
  endtask

  task automatic test_next;
    logic [1:0] exp_sel [3];
    logic [3:0] exp_chan [3];
    logic [7:0] exp_led [3];
    exp_sel  = '{2'd2, 2'd3, 2'd0};
    exp_chan = '{4'b1011, 4'b0111, 4'b1110};
    exp_led  = '{8'hF0, 8'h7E, 8'h5A};
    for (int i = 0; i < 3; i++) begin
      press(3'b001);
      total++; if (sel !== exp_sel[i]) begin bad++; $display("FAIL next%0d_sel got=%0d exp=%0d", i, sel, exp_sel[i]); end
      total++; if (chan_led !== exp_chan[i]) begin bad++; $display("FAIL next%0d_chan got=%b exp=%b", i, chan_led, exp_chan[i]); end
      total++; if (led !== exp_led[i]) begin bad++; $display("FAIL next%0d_led got=%h exp=%h", i, led, exp_led[i]); end
    end
  endtask

  task automatic test_freeze;
    press(3'b010);
    trace_in[7:0] = 8'h00;
    tick(3);
    total++; if (led !== 8'h5A) begin bad++; $display("FAIL frozen_led got=%h exp=5a", led); end
    press(3'b001);
    total++; if (sel !== 2'd0) begin bad++; $display("FAIL frozen_next_sel got=%0d exp=0", sel); end
    total++; if (chan_led !== 4'b1110) begin bad++; $display("FAIL frozen_next_chan got=%b exp=1110", chan_led); end
    press(3'b010);
    total++; if (led !== 8'hFF) begin bad++; $display("FAIL unfrozen_led got=%h exp=ff", led); end
  endtask

  task automatic test_both;
    press(3'b011);
    trace_in[7:0] = 8'h55;
    tick(2);
    total++; if (sel !== 2'd1) begin bad++; $display("FAIL both1_sel got=%0d exp=1", sel); end
    total++; if (led !== 8'hFF) begin bad++; $display("FAIL both1_frozen_led got=%h exp=ff", led); end
    press(3'b011);
    total++; if (sel !== 2'd1) begin bad++; $display("FAIL both2_sel got=%0d exp=1", sel); end
    total++; if (led !== 8'hC3) begin bad++; $display("FAIL both2_unfrozen_led got=%h exp=c3", led); end
  endtask

  task automatic test_socrst;
    int lows;
    int exp_lows;
`ifdef BOARD_IO_BTN_RESET_EN
    exp_lows = 16;
`else
    exp_lows = 0;
`endif
    total++; if (soc_rst_n !== 1'b1) begin bad++; $display("FAIL socrst_pre got=%b exp=1", soc_rst_n); end
    lows = 0;
    btn = 3'b100;
    for (int i = 0; i < 44; i++) begin
      if (i == 14) btn = 3'b000;
      tick(1);
      if (soc_rst_n === 1'b0) lows++;
    end
    total++; if (lows !== exp_lows) begin bad++; $display("FAIL socrst_low_cycles got=%0d exp=%0d", lows, exp_lows); end
    total++; if (soc_rst_n !== 1'b1) begin bad++; $display("FAIL socrst_post got=%b exp=1", soc_rst_n); end
    total++; if (sel !== 2'd1) begin bad++; $display("FAIL socrst_sel got=%0d exp=1", sel); end
    total++; if (led !== 8'hC3) begin bad++; $display("FAIL socrst_led got=%h exp=c3", led); end
  endtask

  initial begin
    test_reset();
    test_trace();
    test_debounce();
    test_next();
    test_freeze();
    test_both();
    test_socrst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/board_io_ctrl.md
BOARD_IO_CTRL -- requirements
Module: board_io_ctrl

Interface
REQ-001 SHALL have parameter CORES, default 4: number of trace channels, 1..8.
REQ-002 SHALL have parameter TRACE_W, default 8: bits per trace channel and LED bank width.
REQ-003 SHALL have parameter RST_W, default 23: width of the SoC reset-stretch counter.
REQ-004 SHALL have parameter DB_W, default 16: width of each button debounce counter.
REQ-005 SHALL have parameter LED_ACTIVE_LOW, default 1: 1 means a driven 0 lights an LED.
REQ-006 SHALL have port clk, input, 1: sole clock; all logic is synchronous to its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port btn, input, 3: raw asynchronous buttons, active-high; bit 0 NEXT, bit 1 FREEZE, bit 2 SOCRST.
REQ-009 SHALL have port trace_in, input, CORES*TRACE_W: channel k occupies bits [k*TRACE_W +: TRACE_W].
REQ-010 SHALL have port soc_rst_n, output, 1: stretched active-low reset to the SoC.
REQ-011 SHALL have port led, output, TRACE_W: selected trace, polarity per LED_ACTIVE_LOW.
REQ-012 SHALL have port chan_led, output, CORES: one-hot selected-channel indicator, polarity per LED_ACTIVE_LOW.
REQ-013 SHALL have port sel, output, max(1,$clog2(CORES)): selected channel index, active-high binary.

Function
REQ-014 SHALL pass each btn bit through a 2-flop synchroniser before any other use.
REQ-015 SHALL keep, per button, a stable state and a DB_W counter; counter clears when the synchronised input equals the stable state, otherwise increments.
REQ-016 SHALL, when the counter is all-ones and the input still differs, update stable, clear the counter and emit a one-cycle press pulse if the new stable value is 1.
REQ-017 SHALL advance sel on a NEXT press: sel+1, wrapping from CORES-1 to 0; CORES=1 keeps sel at 0.
REQ-018 SHALL ignore NEXT presses while frozen.
REQ-019 SHALL toggle the frozen flag on a FREEZE press.
REQ-020 SHALL, on a simultaneous NEXT and FREEZE press, apply the advance only if not frozen before that edge; the toggle always applies.
REQ-021 SHALL register led from trace_in channel sel each cycle (one-cycle latency) when not frozen, and hold it while frozen.
REQ-022 SHALL drive chan_led bit sel lit and all other bits dark, registered with sel.
REQ-023 SHALL keep the reset-stretch counter incrementing while not all-ones and saturating at all-ones.
REQ-024 SHALL register soc_rst_n as the AND-reduction of the reset-stretch counter.
REQ-025 SHALL therefore raise soc_rst_n on the 2^RST_W-th rising edge after rst deasserts.
REQ-026 SHALL apply the LED_ACTIVE_LOW inversion only at the led and chan_led outputs; sel is never inverted.

Reset
REQ-027 SHALL, while rst is high, clear all synchronisers, debounce counters, stable states, frozen, sel and the reset-stretch counter.
REQ-028 SHALL, while rst is high, drive soc_rst_n=0, led all dark and chan_led with bit 0 lit.
REQ-029 SHALL, when rst asserts mid-stretch or mid-debounce, abandon that operation and restart cleanly after rst deasserts.

Configuration
REQ-030 SHALL, with macro BOARD_IO_BTN_RESET_EN defined, clear the reset-stretch counter on an SOCRST press, re-asserting soc_rst_n=0 for 2^RST_W cycles while sel and frozen are preserved.
REQ-031 SHALL, without BOARD_IO_BTN_RESET_EN, debounce btn[2] but leave it with no effect on any output.

Verification
REQ-032 SHALL cover: RST_W=4, rst high 3 cycles then low -> soc_rst_n=0 through edge 15 and =1 from edge 16 after deassert.
REQ-033 SHALL cover: DB_W=3, btn[0] glitch high for 5 cycles -> no sel change; held 12 cycles -> sel 0->1 exactly once.
REQ-034 SHALL cover: CORES=4, four NEXT presses -> sel 1,2,3,0; chan_led (active-low) 4'b1101,1011,0111,1110.
REQ-035 SHALL cover: LED_ACTIVE_LOW=1, trace ch0=8'hA5 -> led=8'h5A one cycle later; FREEZE pressed, ch0 changed to 8'h00 -> led stays 8'h5A; NEXT pressed -> sel unchanged.
REQ-036 SHALL cover: simultaneous NEXT+FREEZE press while unfrozen -> sel advances by 1 and frozen=1; repeated while frozen -> sel unchanged and frozen=0.
REQ-037 SHALL cover: with BOARD_IO_BTN_RESET_EN defined and RST_W=4, SOCRST press after soc_rst_n=1 -> soc_rst_n=0 for 16 cycles, sel retained; without the macro -> soc_rst_n stays 1.
